// File: rtl/uart_rx.sv
// UART receiver fed by a 16x baud strobe: 1 start, DATA_BITS data (LSB first), 1 stop.
// Received words leave on a valid/ready port; framing errors and overruns are one-clk pulses.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_16x,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   rx_s;
    state_t                 state_r;
    logic [3:0]             tick_cnt_r;
    logic [3:0]             bit_cnt_r;
    logic [DATA_BITS-1:0]   shift_r;

    assign rx_s = sync_r[SYNC_STAGES-1];

    // Input synchroniser; resets to idle-high so a reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= {SYNC_STAGES{1'b1}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx};
        end
    end

    // Frame FSM on tick_16x, plus the output handshake that runs every clock
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= {DATA_BITS{1'b0}};
            rx_data    <= {DATA_BITS{1'b0}};
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (tick_16x) begin
                case (state_r)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state_r    <= ST_START;
                            tick_cnt_r <= 4'd0;
                        end
                    end
                    ST_START: begin
                        // Re-check the line half a bit in to reject short glitches
                        if (tick_cnt_r == 4'd7) begin
                            tick_cnt_r <= 4'd0;
                            bit_cnt_r  <= 4'd0;
                            if (!rx_s) begin
                                state_r <= ST_DATA;
                            end else begin
                                state_r <= ST_IDLE;
                            end
                        end else begin
                            tick_cnt_r <= tick_cnt_r + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        tick_cnt_r <= tick_cnt_r + 4'd1;
                        if (tick_cnt_r == 4'd15) begin
                            shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == LAST_BIT) begin
                                state_r    <= ST_STOP;
                                tick_cnt_r <= 4'd0;
                            end
                        end
                    end
                    ST_STOP: begin
                        tick_cnt_r <= tick_cnt_r + 4'd1;
                        if (tick_cnt_r == 4'd15) begin
                            if (rx_s) begin
                                state_r <= ST_IDLE;
                                // A word accepted this same clock frees the slot
                                if (!rx_valid || rx_ready) begin
                                    rx_data  <= shift_r;
                                    rx_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                state_r   <= ST_BREAK;
                                frame_err <= 1'b1;
                            end
                        end
                    end
                    ST_BREAK: begin
                        // Wait for the line to return high before hunting for a start bit
                        if (rx_s) begin
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        tick_cnt_r <= 4'd0;
                        bit_cnt_r  <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serialises 8N1 frames at 64 clks/bit and scoreboards
// every accepted word against a queue of expected bytes.
module tb_uart_rx;

    logic       clk;
    logic       reset;
    logic       tick_16x;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int words_rx = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick_16x  (tick_16x),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Baud strobe: one clock high out of every four
    initial begin
        int div;
        div = 0;
        tick_16x = 1'b0;
        forever begin
            @(negedge clk);
            tick_16x = (div == 0);
            div = (div + 1) % 4;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Monitor samples after the falling edge, when inputs for the next rising edge are settled
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!reset && rx_valid && rx_ready) begin
                words_rx++;
                check_eq("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
                end
            end
            if (!reset && frame_err) begin
                fe_cnt++;
                check_eq("fe_ov_excl", 32'(overrun), 32'd0);
            end
            if (!reset && overrun) begin
                ov_cnt++;
            end
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (64) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
        end
        send_bit(stop);
    endtask

    task automatic idle(input int clks);
        rx = 1'b1;
        repeat (clks) @(negedge clk);
    endtask

    task automatic wait_words(input int target, input string tag);
        int n;
        n = 0;
        while (words_rx < target && n < 2000) begin
            @(negedge clk);
            #3;
            n++;
        end
        check_eq(tag, 32'(words_rx), 32'(target));
    endtask

    initial begin
        int base;
        reset    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        check_eq("rst_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_data", 32'(rx_data), 32'd0);
        check_eq("rst_fe", 32'(frame_err), 32'd0);
        check_eq("rst_ov", 32'(overrun), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(64);

        // 1: plain frame
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(64);
        wait_words(1, "t1_words");
        check_eq("t1_fe", 32'(fe_cnt), 32'd0);
        check_eq("t1_ov", 32'(ov_cnt), 32'd0);

        // 2: 4-tick glitch rejected
        rx = 1'b0;
        repeat (16) @(negedge clk);
        idle(192);
        check_eq("t2_words", 32'(words_rx), 32'd1);
        check_eq("t2_fe", 32'(fe_cnt), 32'd0);

        // 3: framing error with held-low line, then recovery
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (192) @(negedge clk);
        idle(64);
        check_eq("t3_fe", 32'(fe_cnt), 32'd1);
        check_eq("t3_words", 32'(words_rx), 32'd1);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        idle(64);
        wait_words(2, "t3_words_b");

        // 4: overrun while downstream stalls
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        idle(16);
        send_frame(8'h22, 1'b1);
        idle(64);
        #3;
        check_eq("t4_ov", 32'(ov_cnt), 32'd1);
        check_eq("t4_valid", 32'(rx_valid), 32'd1);
        check_eq("t4_data", 32'(rx_data), 32'h11);
        @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        #3;
        check_eq("t4_valid_drop", 32'(rx_valid), 32'd0);
        check_eq("t4_data_hold", 32'(rx_data), 32'h11);
        check_eq("t4_words", 32'(words_rx), 32'd3);

        // 5: reset in the middle of data bit 3 of 0xF0
        base = words_rx;
        idle(32);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) begin
            send_bit(1'b0);
        end
        rx = 1'b0;
        repeat (32) @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #3;
        check_eq("t5_valid", 32'(rx_valid), 32'd0);
        check_eq("t5_data", 32'(rx_data), 32'd0);
        check_eq("t5_fe", 32'(frame_err), 32'd0);
        check_eq("t5_ov", 32'(overrun), 32'd0);
        idle(128);
        check_eq("t5_noword", 32'(words_rx), 32'(base));
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        idle(64);
        wait_words(base + 1, "t5_words");

        // 6: back-to-back frames, no idle gap
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(64);
        wait_words(base + 3, "t6_words");

        check_eq("q_drained", 32'(exp_q.size()), 32'd0);
        check_eq("total_fe", 32'(fe_cnt), 32'd1);
        check_eq("total_ov", 32'(ov_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
